// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - settle-and-compare response monitor for two-input gate benches
// Waits for each {a,b} vector to hold SETTLE cycles, grades out once, and keeps run results.
module gate_response_checker #(
    parameter int OP     = 0,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic             b,
    input  logic             out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic             checked_q, checked_d;
    logic [CNT_W-1:0] cc_q, cc_d;
    logic [CNT_W-1:0] ec_q, ec_d;
    logic             fev_q, fev_d;
    logic [2:0]       fvec_q, fvec_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;

    logic [1:0] vec_now;
    logic       expected;
    logic       mismatch;
    logic       check_due;

    function automatic logic gate_fn(input logic ia, input logic ib);
        case (OP)
            0:       gate_fn = ia & ib;
            1:       gate_fn = ia | ib;
            2:       gate_fn = ia ^ ib;
            default: gate_fn = ~(ia & ib);
        endcase
    endfunction

    assign vec_now  = {a, b};
    assign expected = gate_fn(a, b);
    assign mismatch = (out != expected);

    // Settle tracking and run control; check_due marks the single grading edge of a vector.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        checked_d = checked_q;
        check_due = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    vec_d     = vec_now;
                    settle_d  = SETTLE_L;
                    checked_d = 1'b0;
                end
            end
            S_RUN: begin
                if (vec_now != vec_q) begin
                    vec_d     = vec_now;
                    settle_d  = SETTLE_L;
                    checked_d = 1'b0;
                end else if (!checked_q) begin
                    if (settle_q <= 4'd1) begin
                        check_due = 1'b1;
                        checked_d = 1'b1;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                if (stop) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result bookkeeping: cleared on every run start, updated only on a check edge.
    always_comb begin
        cc_d   = cc_q;
        ec_d   = ec_q;
        fev_d  = fev_q;
        fvec_d = fvec_q;
        fidx_d = fidx_q;
        if ((state_q != S_RUN) && start) begin
            cc_d   = '0;
            ec_d   = '0;
            fev_d  = 1'b0;
            fvec_d = 3'b000;
            fidx_d = '0;
        end else if (check_due) begin
            if (cc_q != CNT_MAX) begin
                cc_d = cc_q + CNT_ONE;
            end
            if (mismatch) begin
                if (ec_q != CNT_MAX) begin
                    ec_d = ec_q + CNT_ONE;
                end
                if (!fev_q) begin
                    fev_d  = 1'b1;
                    fvec_d = {a, b, out};
                    fidx_d = cc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_q     <= 2'b00;
            settle_q  <= 4'd0;
            checked_q <= 1'b0;
            cc_q      <= '0;
            ec_q      <= '0;
            fev_q     <= 1'b0;
            fvec_q    <= 3'b000;
            fidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            checked_q <= checked_d;
            cc_q      <= cc_d;
            ec_q      <= ec_d;
            fev_q     <= fev_d;
            fvec_q    <= fvec_d;
            fidx_q    <= fidx_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (ec_q == '0) && (cc_q != '0);
    assign check_count     = cc_q;
    assign err_count       = ec_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;
    assign first_err_idx   = fidx_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - directed and random grading of gate_response_checker
// Two instances (AND/SETTLE=2/16-bit, XOR/SETTLE=3/3-bit) share stimulus and are graded by a model.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic out0 = 1'b0;
    logic out1 = 1'b0;
    logic inj0 = 1'b0;
    logic inj1 = 1'b0;

    logic        busy0, done0, pass0, fev0;
    logic [15:0] cc0, ec0, fidx0;
    logic [2:0]  fvec0;
    logic        busy1, done1, pass1, fev1;
    logic [2:0]  cc1, ec1, fidx1;
    logic [2:0]  fvec1;

    int nvec = 0;
    int nmis = 0;

    int settle_p[2] = '{2, 3};
    int op_p[2]     = '{0, 2};
    int mx[2]       = '{65535, 7};
    int m_st[2], m_cur[2], m_len[2], m_done_chk[2];
    int m_cc[2], m_ec[2], m_fev[2], m_fvec[2], m_fidx[2];

    always #5 clk = ~clk;

    gate_response_checker #(.OP(0), .SETTLE(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .check_count(cc0), .err_count(ec0),
        .first_err_valid(fev0), .first_err_vec(fvec0), .first_err_idx(fidx0)
    );

    gate_response_checker #(.OP(2), .SETTLE(3), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .check_count(cc1), .err_count(ec1),
        .first_err_valid(fev1), .first_err_vec(fvec1), .first_err_idx(fidx1)
    );

    function automatic int gexp(input int op, input int ia, input int ib);
        case (op)
            0:       return ia & ib;
            1:       return ia | ib;
            2:       return ia ^ ib;
            default: return (ia & ib) ? 0 : 1;
        endcase
    endfunction

    // A vector is graded once it has been seen unchanged on SETTLE consecutive run edges.
    task automatic model_step(input int k, input int o);
        int v, e;
        v = {30'd0, a, b};
        if (!rst_n) begin
            m_st[k] = 0; m_cur[k] = 0; m_len[k] = 0; m_done_chk[k] = 0;
            m_cc[k] = 0; m_ec[k] = 0; m_fev[k] = 0; m_fvec[k] = 0; m_fidx[k] = 0;
            return;
        end
        if (m_st[k] != 1) begin
            if (start) begin
                m_st[k] = 1; m_cur[k] = v; m_len[k] = 0; m_done_chk[k] = 0;
                m_cc[k] = 0; m_ec[k] = 0; m_fev[k] = 0; m_fvec[k] = 0; m_fidx[k] = 0;
            end
        end else begin
            if (v != m_cur[k]) begin
                m_cur[k] = v; m_len[k] = 0; m_done_chk[k] = 0;
            end else if (m_done_chk[k] == 0) begin
                m_len[k] = m_len[k] + 1;
                if (m_len[k] == settle_p[k]) begin
                    m_done_chk[k] = 1;
                    e = gexp(op_p[k], int'(a), int'(b));
                    if (o != e && m_fev[k] == 0) begin
                        m_fev[k] = 1;
                        m_fvec[k] = v * 2 + o;
                        m_fidx[k] = m_cc[k];
                    end
                    if (m_cc[k] < mx[k]) m_cc[k] = m_cc[k] + 1;
                    if (o != e && m_ec[k] < mx[k]) m_ec[k] = m_ec[k] + 1;
                end
            end
            if (stop) m_st[k] = 2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic bz, input logic dn, input logic ps,
                             input logic [31:0] cc, input logic [31:0] ec, input logic fv,
                             input logic [31:0] fvec, input logic [31:0] fidx);
        chk($sformatf("d%0d.busy", k), 32'(bz), 32'(m_st[k] == 1));
        chk($sformatf("d%0d.done", k), 32'(dn), 32'(m_st[k] == 2));
        chk($sformatf("d%0d.pass", k), 32'(ps), 32'(m_st[k] == 2 && m_ec[k] == 0 && m_cc[k] != 0));
        chk($sformatf("d%0d.check_count", k), cc, m_cc[k]);
        chk($sformatf("d%0d.err_count", k), ec, m_ec[k]);
        chk($sformatf("d%0d.first_err_valid", k), 32'(fv), m_fev[k]);
        chk($sformatf("d%0d.first_err_vec", k), fvec, m_fvec[k]);
        chk($sformatf("d%0d.first_err_idx", k), fidx, m_fidx[k]);
    endtask

    task automatic drive_outs();
        out0 = 1'(gexp(0, int'(a), int'(b))) ^ inj0;
        out1 = 1'(gexp(2, int'(a), int'(b))) ^ inj1;
    endtask

    task automatic tick();
        model_step(0, int'(out0));
        model_step(1, int'(out1));
        @(posedge clk);
        #1;
        check_dut(0, busy0, done0, pass0, 32'(cc0), 32'(ec0), fev0, 32'(fvec0), 32'(fidx0));
        check_dut(1, busy1, done1, pass1, 32'(cc1), 32'(ec1), fev1, 32'(fvec1), 32'(fidx1));
    endtask

    task automatic hold(input logic [1:0] v, input int n, input logic f0);
        {a, b} = v;
        inj0 = f0;
        inj1 = 1'b0;
        drive_outs();
        repeat (n) tick();
    endtask

    task automatic pulse_start(input logic [1:0] v, input logic f0);
        {a, b} = v;
        inj0 = f0;
        drive_outs();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic gate_sequence(input logic fault_at_11);
        pulse_start(2'b00, 1'b0);
        hold(2'b00, 9, 1'b0);
        hold(2'b10, 10, 1'b0);
        hold(2'b11, 10, fault_at_11);
        hold(2'b01, 10, 1'b0);
        pulse_stop();
    endtask

    initial begin
        rst_n = 1'b0;
        hold(2'b00, 3, 1'b0);
        chk("reset.busy", 32'(busy0), 0);
        chk("reset.check_count", 32'(cc0), 0);
        rst_n = 1'b1;
        tick();

        // clean AND run
        gate_sequence(1'b0);
        chk("clean.check_count", 32'(cc0), 4);
        chk("clean.err_count", 32'(ec0), 0);
        chk("clean.pass", 32'(pass0), 1);
        chk("clean.done", 32'(done0), 1);

        // injected fault at ab=11
        gate_sequence(1'b1);
        chk("fault.err_count", 32'(ec0), 1);
        chk("fault.first_err_vec", 32'(fvec0), 32'b110);
        chk("fault.first_err_idx", 32'(fidx0), 2);
        chk("fault.pass", 32'(pass0), 0);

        // glitch filtering on the SETTLE=3 instance
        pulse_start(2'b00, 1'b0);
        hold(2'b00, 5, 1'b0);
        chk("glitch.first00", 32'(cc1), 1);
        hold(2'b01, 2, 1'b0);
        hold(2'b00, 3, 1'b0);
        chk("glitch.resettling", 32'(cc1), 1);
        hold(2'b00, 1, 1'b0);
        chk("glitch.rechecked", 32'(cc1), 2);
        hold(2'b00, 6, 1'b0);
        chk("glitch.once", 32'(cc1), 2);
        pulse_stop();

        // stop on the edge a mismatching check is due
        pulse_start(2'b11, 1'b1);
        tick();
        pulse_stop();
        chk("stopdue.check_count", 32'(cc0), 1);
        chk("stopdue.err_count", 32'(ec0), 1);
        chk("stopdue.done", 32'(done0), 1);

        // empty run
        pulse_start(2'b00, 1'b0);
        pulse_stop();
        chk("empty.check_count", 32'(cc0), 0);
        chk("empty.pass", 32'(pass0), 0);
        chk("empty.done", 32'(done0), 1);

        // reset mid-run with two errors
        pulse_start(2'b11, 1'b1);
        hold(2'b11, 3, 1'b1);
        hold(2'b10, 4, 1'b1);
        chk("midrst.err_before", 32'(ec0), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst.err_count", 32'(ec0), 0);
        chk("midrst.busy", 32'(busy0), 0);
        chk("midrst.first_err_valid", 32'(fev0), 0);

        // start and stop together in IDLE: start wins
        {a, b} = 2'b01;
        inj0 = 1'b0;
        drive_outs();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop.busy", 32'(busy0), 1);
        hold(2'b01, 4, 1'b0);
        pulse_stop();
        chk("restart.prev_done", 32'(done0), 1);
        chk("restart.prev_cc", 32'(cc0), 1);
        pulse_start(2'b01, 1'b0);
        chk("restart.done", 32'(done0), 0);
        chk("restart.check_count", 32'(cc0), 0);

        // random vectors, random faults, random start/stop pulses
        for (int i = 0; i < 250; i++) begin
            int n;
            {a, b} = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                inj0 = ($urandom_range(0, 3) == 0);
                inj1 = ($urandom_range(0, 3) == 0);
                drive_outs();
                start = ($urandom_range(0, 14) == 0);
                stop = ($urandom_range(0, 39) == 0);
                tick();
                start = 1'b0;
                stop = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Self-checking response monitor for two-input gate benches: observes the stimulus (`a`, `b`) and the DUT output (`out`), waits for each new input vector to settle, then compares `out` against the expected gate function. Keeps check and error counts, captures the first mismatch, and reports pass/fail when the run ends. It sits on the observation side of a gate testbench, alongside the stimulus sequence, so benches grade themselves instead of relying on waveform inspection.

## Interface
- `OP`, default 0: expected function; 0 AND, 1 OR, 2 XOR, 3 NAND.
- `SETTLE`, default 2: cycles a vector must stay stable before it is checked; legal range 1..15.
- `CNT_W`, default 16: width of all counters and indices.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a run.
- `stop` input 1: one-cycle pulse that ends a run.
- `a`, `b` input 1 each: stimulus as driven into the DUT.
- `out` input 1: DUT response.
- `busy` output 1: run in progress.
- `done` output 1: run finished; results valid.
- `pass` output 1: `done` with zero errors and at least one check.
- `check_count` output CNT_W: vectors checked.
- `err_count` output CNT_W: mismatches found.
- `first_err_valid` output 1: a mismatch has been captured.
- `first_err_vec` output 3: `{a,b,out}` at the first mismatch.
- `first_err_idx` output CNT_W: value of `check_count` before the first failing check (0-based).

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE. All outputs reset to 0.
- **IDLE**
  - `start` causes a transition to RUN.
  - On the same edge, counters and first-error fields are cleared, `{a,b}` is captured as the current vector, and the settle counter is loaded with SETTLE.
- **RUN**
  - `busy` = 1.
  - **Vector change:** if `{a,b}` differs from the captured vector, the block recaptures it, reloads the settle counter and marks the vector unchecked.
  - **Settle and check:** otherwise, if the vector is unchecked, the settle counter decrements. When it is 1 on an edge, the block performs the check and marks the vector checked. Each stable vector is checked exactly once.
  - **Check:**
    - expected = f(OP, a, b).
    - `check_count` increments, saturating at all-ones.
    - On mismatch, `err_count` increments, also saturating.
    - If `first_err_valid` = 0, the block sets it and latches `first_err_vec` and `first_err_idx`.
  - `stop` causes a transition to DONE. If a check is due on the same edge, it is performed first, so it is counted.
  - `start` while in RUN is ignored.
- **DONE**
  - Outputs: `busy` = 0, `done` = 1, `pass` = (`err_count` == 0) && (`check_count` != 0).
  - Counts hold their values.
  - `start` clears the results and re-enters RUN exactly as from IDLE; `done` and `pass` drop on that edge.
  - `stop` in IDLE or DONE is ignored.
- **Reset:** `rst_n` = 0 mid-run returns the block to IDLE with all outputs 0 on that edge. No partial results are retained.
- **Saturation:** counts stop at 2^CNT_W−1. `first_err_idx` is never modified after capture.

## Timing
- **Check latency:** when a vector is captured at edge T and held stable, its check updates the counts at edge T+SETTLE. The updated values are visible in the cycle after that edge.
- **Changes during settling:** any input change before T+SETTLE restarts settling from the edge where the change is seen. A glitch shorter than SETTLE cycles is therefore never checked.
- **Single-vector runs:** a vector present at `start` is checked at start-edge+SETTLE without needing a change.
- **End of run:** `done` asserts the cycle after the `stop` edge. `pass` is valid together with `done`.
- **`out` sampling:** `out` is sampled only on the check edge. Earlier values of `out` are don't-care.
- **Simultaneous events:**
  - Vector change and `stop` on the same edge: the old vector is not checked if it was still settling; the new vector is never checked.
  - `start` and `stop` on the same edge in IDLE: `start` wins and the block enters RUN.

## Test plan
- **Clean AND run:** OP=0, SETTLE=2. Start, then drive `ab` = 00, 10, 11, 01, each held 10 cycles, with a correct DUT; stop. Required: `check_count`=4, `err_count`=0, `pass`=1, `done`=1.
- **Injected fault:** same sequence, with `out` forced to 0 while `ab`=11. Required: `err_count`=1, `first_err_vec`=3'b110, `first_err_idx`=2, `pass`=0.
- **Glitch filtering:** SETTLE=3. Hold `ab`=00, pulse `b` to 1 for 2 cycles, return to 00, then hold. Required: the 01 vector is not checked; the 00 vector is checked once after re-stabilising (after 3 stable cycles); `check_count` increments by 1 per stable vector.
- **Stop coinciding with a due check:** assert `stop` on the edge where a check is due, with a mismatching `out`. Required: that check is counted, `err_count`=1, `done` next cycle.
- **Empty run:** start then stop after 1 cycle with SETTLE=2. Required: `check_count`=0, `pass`=0, `done`=1.
- **Reset mid-run, then restart:** drop `rst_n` mid-run with `err_count`=2. Required: all outputs 0 and state IDLE next cycle. Then a `start` from DONE after a run: counts clear and `done`=0 after that edge.
